fetch_aligner: RTL and testbench
================================

Name: fetch_aligner

Overview:
Sits between the instruction memory port and the decoder. It realigns a stream of 32-bit fetch words into whole RV32IC instructions, either 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. It presents one instruction per cycle, with its PC and a compressed flag, to the decoder under a valid/ready handshake. It owns the sequential fetch address and restarts cleanly on a branch/jump redirect from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 must be 0.
QDEPTH, 4, halfword queue depth; fixed at 4, other values unsupported.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
o_fetch_addr  output  32  word-aligned imem read address (bits[1:0]=0)
i_fetch_data  input  32  imem word at o_fetch_addr, combinational same cycle
i_fetch_valid  input  1  i_fetch_data valid this cycle
o_fetch_ready  output  1  aligner accepts the word this cycle
i_redirect  input  1  jump/taken-branch flush from execute
i_redirect_pc  input  32  new PC, halfword aligned; bit 0 ignored
o_valid  output  1  o_instr/o_pc hold a complete instruction
i_ready  input  1  decoder consumes the instruction (low = stall)
o_instr  output  32  instruction; compressed form zero-extended to {16'h0, hw}
o_compressed  output  1  1 when o_instr is a 16-bit instruction
o_pc  output  32  PC of o_instr
o_stall_cnt  output  32  decoder-stall cycle counter (see Optional Feature)

Behaviour:
- State: 4-entry halfword queue (hw[0] = head), count 0..4, head_pc, fetch_addr, drop_lo flag.
- Reset (reset=0, asynchronous): count=0, head_pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}, drop_lo=RESET_PC[1], o_valid=0, o_instr=0, o_compressed=0, o_pc=RESET_PC, o_stall_cnt=0.
- Push: word accepted when i_fetch_valid && o_fetch_ready.
  - o_fetch_ready = !i_redirect && (count - pops_this_cycle) <= 2.
  - On accept, append {hi,lo} halfwords (lo first) and set fetch_addr += 4.
  - If drop_lo=1, append hi only, then clear drop_lo.
- Head decode: compressed iff hw[0][1:0] != 2'b11.
  - o_valid = !i_redirect && ((compressed && count>=1) || (!compressed && count>=2)).
  - o_instr = compressed ? {16'h0,hw[0]} : {hw[1],hw[0]}.
  - o_pc = head_pc; outputs are combinational from queue state.
- Pop: when o_valid && i_ready, pop 1 halfword (compressed) or 2, and head_pc += 2 or 4.
- Push and pop in the same cycle are both performed. The new count = count - pop + push and never exceeds 4.
- Straddling 32-bit instruction (low half in the last slot of word N): o_valid stays 0 until word N+1 is pushed, then it is presented. Zero-cycle bypass from i_fetch_data is not allowed.
- Redirect (i_redirect=1) has priority over push and pop; no handshake completes that cycle. Next cycle:
  - count=0, head_pc={i_redirect_pc[31:1],1'b0}
  - fetch_addr={i_redirect_pc[31:2],2'b00}, drop_lo=i_redirect_pc[1]
- Redirect during stall or with a partially buffered instruction: buffered halfwords are discarded, nothing is emitted.
- fetch_addr and head_pc wrap modulo 2^32 without error.
- Back-to-back redirects: the last one wins.
- Fetch latency: from redirect to first o_valid is 2 cycles, given i_fetch_valid=1 and a compressed or word-aligned target.
- Steady state: one instruction per cycle for any mix of 16-bit and 32-bit instructions, with no bubbles.

Optional Feature:
FETCH_ALIGN_PERF_EN
- Defined: o_stall_cnt is a 32-bit saturating counter, reset to 0. It increments every cycle with o_valid=1 && i_ready=0 and holds at 32'hFFFF_FFFF.
- Not defined: o_stall_cnt is tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0, words 0x00000013 (nop) and 0x00100093: o_pc=0 then 4; o_compressed=0; o_instr=0x00000013 then 0x00100093.
2. Word 0x45014501 (two c.li a0,0): o_instr=0x00004501 at pc 0 and 2, o_compressed=1, back-to-back cycles; next word fetched from addr 4.
3. Straddle: word0=0x00934501 (c.li, low half of addi), word1=0x00000010: outputs 0x00004501 @0, then 0x00100093 @2 after word1 accepted.
4. Redirect to 0x00000102 while queue count=3: next cycle count=0; fetch_addr=0x100; lower half of word 0x100 dropped; first o_pc=0x102.
5. Hold i_ready=0 for 5 cycles with o_valid=1: o_instr/o_pc stable, o_fetch_ready falls once count reaches 3+; with FETCH_ALIGN_PERF_EN, o_stall_cnt=5.
6. Assert reset low mid-stream, asynchronously, between clock edges: o_valid=0 and o_pc=RESET_PC immediately; resumes from RESET_PC after release.

Source files
------------

// File: rtl/fetch_aligner.sv
// Realigns 32-bit fetch words into whole RV32IC instructions (16- or 32-bit) for the decoder.
// Optional decoder-stall counter enabled by defining FETCH_ALIGN_PERF_EN.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,

    output logic [31:0] o_fetch_addr,
    input  logic [31:0] i_fetch_data,
    input  logic        i_fetch_valid,
    output logic        o_fetch_ready,

    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,

    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic        o_compressed,
    output logic [31:0] o_pc,
    output logic [31:0] o_stall_cnt
);

    // A word is accepted only if two free slots remain after this cycle's pop.
    localparam logic [2:0] FillLimit = 3'(QDEPTH - 2);

    logic [3:0][15:0] q_q, q_d, q_shift;
    logic [2:0]       count_q, count_d;
    logic [31:0]      head_pc_q, head_pc_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic             drop_lo_q, drop_lo_d;

    logic       head_comp;
    logic [2:0] need;
    logic       pop;
    logic [2:0] pop_n;
    logic [2:0] after_pop;
    logic       push;
    logic [2:0] push_n;
    logic       unused_redirect_lsb;

    assign unused_redirect_lsb = i_redirect_pc[0];

    assign head_comp = (q_q[0][1:0] != 2'b11);
    assign need      = head_comp ? 3'd1 : 3'd2;
    assign o_valid   = !i_redirect && (count_q >= need);

    assign pop       = o_valid && i_ready;
    assign pop_n     = pop ? need : 3'd0;
    assign after_pop = count_q - pop_n;

    assign o_fetch_ready = !i_redirect && (after_pop <= FillLimit);
    assign push          = i_fetch_valid && o_fetch_ready;
    assign push_n        = !push ? 3'd0 : (drop_lo_q ? 3'd1 : 3'd2);

    assign o_fetch_addr = fetch_addr_q;
    assign o_pc         = head_pc_q;
    assign o_compressed = o_valid && head_comp;
    assign o_instr      = !o_valid ? 32'h0 :
                          (head_comp ? {16'h0, q_q[0]} : {q_q[1], q_q[0]});

    // Shift out popped halfwords, then append the new word behind what remains.
    assign q_shift = q_q >> {pop_n, 4'b0000};

    always_comb begin
        q_d = q_shift;
        for (int i = 0; i < 4; i++) begin
            if (push && drop_lo_q && (after_pop == 3'(i))) begin
                q_d[i] = i_fetch_data[31:16];
            end
            if (push && !drop_lo_q && (after_pop == 3'(i))) begin
                q_d[i] = i_fetch_data[15:0];
            end
            if (push && !drop_lo_q && ((after_pop + 3'd1) == 3'(i))) begin
                q_d[i] = i_fetch_data[31:16];
            end
        end
    end

    always_comb begin
        count_d      = after_pop + push_n;
        head_pc_d    = head_pc_q + {28'd0, pop_n, 1'b0};
        fetch_addr_d = push ? (fetch_addr_q + 32'd4) : fetch_addr_q;
        drop_lo_d    = push ? 1'b0 : drop_lo_q;
        if (i_redirect) begin
            count_d      = 3'd0;
            head_pc_d    = {i_redirect_pc[31:1], 1'b0};
            fetch_addr_d = {i_redirect_pc[31:2], 2'b00};
            drop_lo_d    = i_redirect_pc[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q          <= '0;
            count_q      <= 3'd0;
            head_pc_q    <= RESET_PC;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            drop_lo_q    <= RESET_PC[1];
        end else begin
            q_q          <= q_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_lo_q    <= drop_lo_d;
        end
    end

`ifdef FETCH_ALIGN_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'h0;
        end else if (o_valid && !i_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: directed scenarios plus randomized traffic checked against
// an instruction-stream model that walks a hashed memory image by PC.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] o_fetch_addr;
    logic [31:0] i_fetch_data;
    logic        i_fetch_valid = 1'b0;
    logic        o_fetch_ready;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_instr;
    logic        o_compressed;
    logic [31:0] o_pc;
    logic [31:0] o_stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned hs       = 0;
    int unsigned stalls   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_stall;
    logic        use_dir = 1'b1;
    logic [31:0] dir_mem [256];

    fetch_aligner #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .o_fetch_addr  (o_fetch_addr),
        .i_fetch_data  (i_fetch_data),
        .i_fetch_valid (i_fetch_valid),
        .o_fetch_ready (o_fetch_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_compressed  (o_compressed),
        .o_pc          (o_pc),
        .o_stall_cnt   (o_stall_cnt)
    );

    always #5 clk = ~clk;

    // Pseudo-random program image, biased towards 32-bit instructions.
    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] x;
        x = {a[31:1], 1'b0} * 32'h9E37_79B1;
        x = x ^ (x >> 13);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 16);
        return x[20] ? {x[15:2], 2'b11} : x[15:0];
    endfunction

    function automatic logic [31:0] ref_instr(input logic [31:0] pc);
        logic [15:0] lo;
        lo = hw_at(pc);
        if (lo[1:0] != 2'b11) return {16'h0, lo};
        return {hw_at(pc + 32'd2), lo};
    endfunction

    always_comb begin
        if (use_dir) i_fetch_data = dir_mem[o_fetch_addr[9:2]];
        else         i_fetch_data = {hw_at(o_fetch_addr + 32'd2), hw_at(o_fetch_addr)};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        i_fetch_valid = 1'b0;
        i_ready       = 1'b1;
        i_redirect    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One cycle of model-checked traffic; inputs already driven at edge+1.
    task automatic model_cycle(input bit expect_valid);
        logic [31:0] ei;
        #1;
        if (expect_valid) check_eq("no_bubble", 32'(o_valid), 32'd1);
        check_eq("fetch_addr_align", {30'd0, o_fetch_addr[1:0]}, 32'd0);
        if (i_redirect) begin
            check_eq("redirect_blocks_valid", 32'(o_valid), 32'd0);
            exp_pc = {i_redirect_pc[31:1], 1'b0};
        end else if (o_valid) begin
            if (i_ready) begin
                ei = ref_instr(exp_pc);
                check_eq("rand_pc", o_pc, exp_pc);
                check_eq("rand_instr", o_instr, ei);
                check_eq("rand_comp", 32'(o_compressed), 32'(ei[1:0] != 2'b11));
                exp_pc = exp_pc + ((ei[1:0] != 2'b11) ? 32'd2 : 32'd4);
                hs++;
            end else begin
                stalls++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) dir_mem[i] = 32'h0000_0013;

        // Reset values and two aligned 32-bit instructions
        apply_reset();
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_pc", o_pc, 32'h0);
        check_eq("rst_instr", o_instr, 32'h0);
        check_eq("rst_comp", 32'(o_compressed), 32'd0);
        check_eq("rst_stall", o_stall_cnt, 32'h0);
        check_eq("rst_faddr", o_fetch_addr, 32'h0);
        dir_mem[0] = 32'h0000_0013;
        dir_mem[1] = 32'h0010_0093;
        use_dir = 1'b1;
        i_fetch_valid = 1'b1;
        reset = 1'b1;
        step();
        check_eq("t1_valid0", 32'(o_valid), 32'd1);
        check_eq("t1_pc0", o_pc, 32'h0);
        check_eq("t1_instr0", o_instr, 32'h0000_0013);
        check_eq("t1_comp0", 32'(o_compressed), 32'd0);
        step();
        check_eq("t1_pc1", o_pc, 32'h4);
        check_eq("t1_instr1", o_instr, 32'h0010_0093);

        // Two compressed instructions in one word, back to back
        apply_reset();
        dir_mem[0] = 32'h4501_4501;
        dir_mem[1] = 32'h4501_4501;
        i_fetch_valid = 1'b1;
        reset = 1'b1;
        step();
        check_eq("t2_pc0", o_pc, 32'h0);
        check_eq("t2_instr0", o_instr, 32'h0000_4501);
        check_eq("t2_comp0", 32'(o_compressed), 32'd1);
        check_eq("t2_faddr", o_fetch_addr, 32'h4);
        step();
        check_eq("t2_valid1", 32'(o_valid), 32'd1);
        check_eq("t2_pc1", o_pc, 32'h2);
        check_eq("t2_instr1", o_instr, 32'h0000_4501);

        // Redirect to a halfword target with three halfwords buffered
        dir_mem[64] = 32'h4585_4501;
        dir_mem[65] = 32'h4501_4501;
        dir_mem[66] = 32'h4501_4501;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0103;
        #1;
        check_eq("t4_valid_redir", 32'(o_valid), 32'd0);
        check_eq("t4_fready_redir", 32'(o_fetch_ready), 32'd0);
        step();
        i_redirect = 1'b0;
        check_eq("t4_faddr", o_fetch_addr, 32'h100);
        check_eq("t4_valid_empty", 32'(o_valid), 32'd0);
        check_eq("t4_pc_target", o_pc, 32'h102);
        step();
        check_eq("t4_valid", 32'(o_valid), 32'd1);
        check_eq("t4_pc", o_pc, 32'h102);
        check_eq("t4_instr", o_instr, 32'h0000_4585);
        check_eq("t4_faddr2", o_fetch_addr, 32'h104);

        // Decoder stall for five cycles
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t5_pc_hold", o_pc, 32'h102);
            check_eq("t5_instr_hold", o_instr, 32'h0000_4585);
        end
        check_eq("t5_fready_low", 32'(o_fetch_ready), 32'd0);
`ifdef FETCH_ALIGN_PERF_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        check_eq("t5_stall_cnt", o_stall_cnt, exp_stall);

        // Asynchronous reset between clock edges
        i_ready = 1'b1;
        step();
        reset = 1'b0;
        #2;
        check_eq("t6_valid_async", 32'(o_valid), 32'd0);
        check_eq("t6_pc_async", o_pc, 32'h0);
        check_eq("t6_stall_async", o_stall_cnt, 32'h0);
        #2;
        reset = 1'b1;
        step();
        check_eq("t6_pc_resume", o_pc, 32'h0);
        check_eq("t6_instr_resume", o_instr, 32'h0000_4501);

        // Straddling 32-bit instruction waits for the following word
        apply_reset();
        dir_mem[0] = 32'h0093_4501;
        dir_mem[1] = 32'h0000_0010;
        i_fetch_valid = 1'b1;
        reset = 1'b1;
        step();
        i_fetch_valid = 1'b0;
        check_eq("t3_instr0", o_instr, 32'h0000_4501);
        check_eq("t3_pc0", o_pc, 32'h0);
        step();
        check_eq("t3_wait_valid", 32'(o_valid), 32'd0);
        i_fetch_valid = 1'b1;
        #1;
        check_eq("t3_no_bypass", 32'(o_valid), 32'd0);
        step();
        check_eq("t3_valid", 32'(o_valid), 32'd1);
        check_eq("t3_pc", o_pc, 32'h2);
        check_eq("t3_instr", o_instr, 32'h0010_0093);
        check_eq("t3_comp", 32'(o_compressed), 32'd0);

        // Full-rate stream: no bubbles, including across a wrap at 2^32
        apply_reset();
        use_dir = 1'b0;
        i_fetch_valid = 1'b1;
        reset = 1'b1;
        exp_pc = 32'h0;
        model_cycle(1'b0);
        for (int i = 0; i < 20; i++) model_cycle(1'b1);
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF0;
        model_cycle(1'b0);
        i_redirect = 1'b0;
        model_cycle(1'b0);
        for (int i = 0; i < 100; i++) model_cycle(1'b1);

        // Randomized traffic with stalls, gaps and redirects
        apply_reset();
        reset = 1'b1;
        exp_pc = 32'h0;
        hs = 0;
        stalls = 0;
        for (int i = 0; i < 3000; i++) begin
            i_fetch_valid = ($urandom_range(0, 3) != 0);
            i_ready       = ($urandom_range(0, 3) != 0);
            i_redirect    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0)
                i_redirect_pc = 32'hFFFF_FFF4 + 32'($urandom_range(0, 7));
            else
                i_redirect_pc = $urandom;
            model_cycle(1'b0);
        end
        i_redirect = 1'b0;
`ifdef FETCH_ALIGN_PERF_EN
        exp_stall = 32'(stalls);
`else
        exp_stall = 32'd0;
`endif
        check_eq("rand_stall_cnt", o_stall_cnt, exp_stall);
        check_eq("rand_throughput", 32'(hs > 800), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
